// File: rtl/write_nonsym_pattern_checker.sv
// Write-throughput test sink: packs 32-bit pipe-in words into 64-bit words, checks them
// against an internal reference pattern, counts errors and times the run in okClk cycles.
module write_nonsym_pattern_checker #(
    parameter logic [63:0] LFSR_SEED = 64'h1,
    parameter int unsigned CNT_W     = 32
) (
    input  logic             okClk,
    input  logic             reset_n,
    input  logic [31:0]      pattern,
    input  logic             start_timer,
    input  logic             stop_timer,
    input  logic             reset_pattern,
    input  logic             pipe_in_write,
    input  logic [31:0]      pipe_in_data,
    output logic             timer_on,
    output logic [63:0]      clk_counts,
    output logic [CNT_W-1:0] word_count,
    output logic [CNT_W-1:0] error_count,
    output logic [CNT_W-1:0] first_err_idx,
    output logic             half_pending,
    output logic             err_pulse
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_STOPPED} state_t;

    state_t      state, state_n;
    logic [1:0]  mode;
    logic [31:0] pat_q;
    logic [31:0] low_half;
    logic [63:0] w_q, r_q;
    logic        cmp_v;
    logic [63:0] cnt_ref, walk_ref, lfsr;
    logic [63:0] ref_sel;
    logic        lfsr_fb;
    logic        start_idle;
    logic        accept;

    // reset_pattern > stop_timer > start_timer: a higher trigger masks the lower ones
    always_comb begin
        state_n = state;
        if (reset_pattern)
            state_n = S_IDLE;
        else if (stop_timer) begin
            if (state == S_RUN)
                state_n = S_STOPPED;
        end else if (start_timer && state != S_RUN)
            state_n = S_RUN;
    end

    always_comb begin
        ref_sel = cnt_ref;
        case (mode)
            2'd0:    ref_sel = cnt_ref;
            2'd1:    ref_sel = walk_ref;
            2'd2:    ref_sel = lfsr;
            default: ref_sel = {pat_q, pat_q};
        endcase
    end

    assign lfsr_fb    = lfsr[63] ^ lfsr[62] ^ lfsr[60] ^ lfsr[59];
    assign start_idle = (state == S_IDLE) && (state_n == S_RUN);
    // strobes on the stop/reset cycle are dropped along with any held half
    assign accept     = pipe_in_write && (state == S_RUN) && (state_n == S_RUN);
    assign timer_on   = (state == S_RUN);

    always_ff @(posedge okClk or negedge reset_n) begin
        if (!reset_n)
            state <= S_IDLE;
        else
            state <= state_n;
    end

    always_ff @(posedge okClk or negedge reset_n) begin
        if (!reset_n) begin
            clk_counts    <= '0;
            word_count    <= '0;
            error_count   <= '0;
            first_err_idx <= '1;
            half_pending  <= 1'b0;
            err_pulse     <= 1'b0;
            mode          <= 2'd0;
            pat_q         <= '0;
            low_half      <= '0;
            w_q           <= '0;
            r_q           <= '0;
            cmp_v         <= 1'b0;
            cnt_ref       <= '0;
            walk_ref      <= 64'h1;
            lfsr          <= LFSR_SEED;
        end else if (reset_pattern) begin
            clk_counts    <= '0;
            word_count    <= '0;
            error_count   <= '0;
            first_err_idx <= '1;
            half_pending  <= 1'b0;
            err_pulse     <= 1'b0;
            cmp_v         <= 1'b0;
            cnt_ref       <= '0;
            walk_ref      <= 64'h1;
            lfsr          <= LFSR_SEED;
        end else begin
            if (state_n == S_RUN)
                clk_counts <= clk_counts + 64'd1;
            if (start_idle) begin
                mode  <= pattern[1:0];
                pat_q <= pattern;
            end

            cmp_v <= accept && half_pending;
            if (accept) begin
                if (!half_pending) begin
                    low_half     <= pipe_in_data;
                    half_pending <= 1'b1;
                end else begin
                    w_q          <= {pipe_in_data, low_half};
                    r_q          <= ref_sel;
                    half_pending <= 1'b0;
                    cnt_ref      <= cnt_ref + 64'd1;
                    walk_ref     <= {walk_ref[62:0], walk_ref[63]};
                    lfsr         <= {lfsr[62:0], lfsr_fb};
                end
            end else if (state == S_RUN && state_n != S_RUN) begin
                half_pending <= 1'b0;
            end

            err_pulse <= 1'b0;
            if (cmp_v) begin
                if (word_count != '1)
                    word_count <= word_count + CNT_W'(1);
                if (w_q != r_q) begin
                    err_pulse <= 1'b1;
                    if (error_count != '1)
                        error_count <= error_count + CNT_W'(1);
                    if (first_err_idx == '1)
                        first_err_idx <= word_count;
                end
            end
        end
    end

endmodule

// File: tb/tb_write_nonsym_pattern_checker.sv
// Bench for write_nonsym_pattern_checker: table of pattern runs plus hand-written
// sequences for stop/restart, timing and reset behaviour; per-word scoreboard on err_pulse.
module tb_write_nonsym_pattern_checker;

    localparam logic [63:0] SEED = 64'h1;

    logic        okClk = 1'b0;
    logic        reset_n;
    logic [31:0] pattern;
    logic        start_timer, stop_timer, reset_pattern;
    logic        pipe_in_write;
    logic [31:0] pipe_in_data;
    logic        timer_on;
    logic [63:0] clk_counts;
    logic [31:0] word_count, error_count, first_err_idx;
    logic        half_pending, err_pulse;

    int n_tests = 0;
    int n_fail  = 0;
    bit exp_q[$];
    logic [31:0] prev_wc = '0;

    write_nonsym_pattern_checker #(.LFSR_SEED(SEED), .CNT_W(32)) dut (
        .okClk(okClk), .reset_n(reset_n), .pattern(pattern),
        .start_timer(start_timer), .stop_timer(stop_timer), .reset_pattern(reset_pattern),
        .pipe_in_write(pipe_in_write), .pipe_in_data(pipe_in_data),
        .timer_on(timer_on), .clk_counts(clk_counts), .word_count(word_count),
        .error_count(error_count), .first_err_idx(first_err_idx),
        .half_pending(half_pending), .err_pulse(err_pulse)
    );

    always #5 okClk = ~okClk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // every completed compare must pop one expected mismatch flag
    always @(negedge okClk) begin
        if (reset_n && word_count == prev_wc + 32'd1) begin
            if (exp_q.size() == 0)
                check("sb_unexpected_word", 64'(word_count), 64'(prev_wc));
            else
                check("sb_err_pulse", 64'(err_pulse), 64'(exp_q.pop_front()));
        end
        prev_wc <= word_count;
    end

    task automatic tick();
        @(posedge okClk);
        #1;
    endtask

    task automatic pulse_reset_pattern();
        reset_pattern = 1'b1;
        tick();
        reset_pattern = 1'b0;
    endtask

    task automatic do_start(input logic [31:0] p);
        pattern     = p;
        start_timer = 1'b1;
        tick();
        start_timer = 1'b0;
        pattern     = '0;
    endtask

    task automatic do_stop();
        stop_timer = 1'b1;
        tick();
        stop_timer = 1'b0;
    endtask

    // low half crosses first; leaves pipe_in_write high so pairs run back-to-back
    task automatic send_pair(input logic [63:0] w);
        pipe_in_write = 1'b1;
        pipe_in_data  = w[31:0];
        tick();
        pipe_in_data  = w[63:32];
        tick();
    endtask

    task automatic idle(input int unsigned n);
        pipe_in_write = 1'b0;
        for (int unsigned i = 0; i < n; i++) tick();
    endtask

    function automatic logic [63:0] ref_word(input logic [31:0] p, input int unsigned k);
        logic [63:0] l;
        case (p[1:0])
            2'd0: return 64'(k);
            2'd1: return 64'h1 << (k % 64);
            2'd2: begin
                l = SEED;
                for (int unsigned i = 0; i < k; i++)
                    l = {l[62:0], l[63] ^ l[62] ^ l[60] ^ l[59]};
                return l;
            end
            default: return {p, p};
        endcase
    endfunction

    typedef struct {
        logic [31:0]  pat;
        int unsigned  nw;
        int           err_at;
        logic [31:0]  exp_wc;
        logic [31:0]  exp_ec;
        logic [31:0]  exp_fei;
    } vec_t;

    vec_t vecs[7];

    initial begin
        logic [63:0] w;

        vecs[0] = '{32'h0,         3,  -1, 32'd3,  32'd0, 32'hFFFF_FFFF};
        vecs[1] = '{32'h0,         3,   2, 32'd3,  32'd1, 32'd2};
        vecs[2] = '{32'h1,         65, -1, 32'd65, 32'd0, 32'hFFFF_FFFF};
        vecs[3] = '{32'h2,         10, -1, 32'd10, 32'd0, 32'hFFFF_FFFF};
        vecs[4] = '{32'h2,         8,   0, 32'd8,  32'd1, 32'd0};
        vecs[5] = '{32'hA5A5_0003, 4,  -1, 32'd4,  32'd0, 32'hFFFF_FFFF};
        vecs[6] = '{32'h1234_5677, 5,   3, 32'd5,  32'd1, 32'd3};

        reset_n = 1'b0; pattern = '0; start_timer = 1'b0; stop_timer = 1'b0;
        reset_pattern = 1'b0; pipe_in_write = 1'b0; pipe_in_data = '0;
        tick(); tick();
        check("rst_timer_on", 64'(timer_on), 64'd0);
        check("rst_clk_counts", clk_counts, 64'd0);
        check("rst_word_count", 64'(word_count), 64'd0);
        check("rst_error_count", 64'(error_count), 64'd0);
        check("rst_first_err", 64'(first_err_idx), 64'hFFFF_FFFF);
        check("rst_half", 64'(half_pending), 64'd0);
        check("rst_err_pulse", 64'(err_pulse), 64'd0);
        reset_n = 1'b1;
        tick();

        foreach (vecs[v]) begin
            pulse_reset_pattern();
            do_start(vecs[v].pat);
            check("vec_timer_on", 64'(timer_on), 64'd1);
            for (int unsigned k = 0; k < vecs[v].nw; k++) begin
                w = ref_word(vecs[v].pat, k);
                if (int'(k) == vecs[v].err_at) w = w ^ 64'h5;
                exp_q.push_back(int'(k) == vecs[v].err_at);
                send_pair(w);
            end
            idle(3);
            check("vec_word_count", 64'(word_count), 64'(vecs[v].exp_wc));
            check("vec_error_count", 64'(error_count), 64'(vecs[v].exp_ec));
            check("vec_first_err", 64'(first_err_idx), 64'(vecs[v].exp_fei));
            check("vec_sb_drained", 64'(exp_q.size()), 64'd0);
        end

        // held low half is discarded by stop; the next pair is checked against R[0]
        pulse_reset_pattern();
        do_start(32'h0);
        pipe_in_write = 1'b1; pipe_in_data = 32'hDEAD_BEEF;
        tick();
        pipe_in_write = 1'b0;
        check("hold_half_set", 64'(half_pending), 64'd1);
        do_stop();
        check("stop_half_clr", 64'(half_pending), 64'd0);
        check("stop_timer_off", 64'(timer_on), 64'd0);
        do_start(32'h0);
        exp_q.push_back(1'b0);
        send_pair(64'h0);
        idle(3);
        check("resume_word_count", 64'(word_count), 64'd1);
        check("resume_error_count", 64'(error_count), 64'd0);

        // run timer: start cycle counts, stop cycle does not
        pulse_reset_pattern();
        do_start(32'h0);
        for (int unsigned i = 0; i < 99; i++) tick();
        check("timer_running", 64'(timer_on), 64'd1);
        do_stop();
        check("clk_counts_100", clk_counts, 64'd100);
        send_pair(64'h0);
        idle(3);
        check("stopped_frozen", clk_counts, 64'd100);
        check("stopped_ignored", 64'(word_count), 64'd0);
        check("stopped_half", 64'(half_pending), 64'd0);

        // asynchronous reset mid-run
        pulse_reset_pattern();
        do_start(32'h0);
        exp_q.push_back(1'b0);
        send_pair(64'h0);
        pipe_in_data = 32'h1;
        tick();
        idle(2);
        #2 reset_n = 1'b0;
        #1;
        check("async_timer_on", 64'(timer_on), 64'd0);
        check("async_word_count", 64'(word_count), 64'd0);
        check("async_half", 64'(half_pending), 64'd0);
        check("async_clk_counts", clk_counts, 64'd0);
        tick();
        reset_n = 1'b1;
        tick();

        // reset_pattern wins over start in the same cycle
        do_start(32'h0);
        exp_q.push_back(1'b1);
        send_pair(64'h9);
        idle(3);
        check("pre_rp_error_count", 64'(error_count), 64'd1);
        reset_pattern = 1'b1; start_timer = 1'b1;
        tick();
        reset_pattern = 1'b0; start_timer = 1'b0;
        check("rp_timer_on", 64'(timer_on), 64'd0);
        check("rp_word_count", 64'(word_count), 64'd0);
        check("rp_error_count", 64'(error_count), 64'd0);
        check("rp_first_err", 64'(first_err_idx), 64'hFFFF_FFFF);
        check("rp_clk_counts", clk_counts, 64'd0);
        tick();
        check("rp_stays_idle", 64'(timer_on), 64'd0);
        check("final_sb_drained", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
